button_debounce_bank: RTL

BUTTON_DEBOUNCE_BANK -- requirements
Module: button_debounce_bank

---
 rtl/button_debounce_bank_pkg.sv | 22 ++
 rtl/button_debounce_bank_if.sv | 32 +++
 rtl/button_debounce_bank_channel.sv | 137 +++++++++++++
 rtl/button_debounce_bank.sv | 70 +++++++
 4 files changed

// File: rtl/button_debounce_bank_pkg.sv
// button_debounce_bank: shared FSM state type, default parameters
// and the counter-width helper.
package button_pkg;

   typedef enum logic [1:0] {
      IDLE,
      ARMING,
      PRESSED,
      RELEASING
   } btn_state_t;

   localparam int N_CH_DEF       = 4;
   localparam int TICK_DIV_DEF   = 50;
   localparam int STABLE_CNT_DEF = 4;
   localparam int LONG_CNT_DEF   = 16;

   // Bits needed to hold 0..max without wrapping.
   function automatic int cnt_w(input int max);
      return (max < 1) ? 1 : $clog2(max + 1);
   endfunction

endpackage

// File: rtl/button_debounce_bank_if.sv
// button_debounce_bank: raw button inputs and debounced event outputs.
// master = button source / event consumer, slave = debouncer.
interface button_debounce_bank_if #(
   parameter int N_CH = button_pkg::N_CH_DEF
);

   logic [N_CH-1:0] btn_in;
   logic [N_CH-1:0] level_o;
   logic [N_CH-1:0] press_o;
   logic [N_CH-1:0] release_o;
   logic [N_CH-1:0] toggle_o;
   logic [N_CH-1:0] long_o;

   modport master (
      output btn_in,
      input  level_o,
      input  press_o,
      input  release_o,
      input  toggle_o,
      input  long_o
   );

   modport slave (
      input  btn_in,
      output level_o,
      output press_o,
      output release_o,
      output toggle_o,
      output long_o
   );

endinterface

// File: rtl/button_debounce_bank_channel.sv
// One debounce channel: synchroniser, qualification FSM, event pulses.
// Long-press hold logic only exists with BUTTON_DEBOUNCE_LONG_PRESS_EN.
module button_channel
   import button_pkg::*;
#(
   parameter int STABLE_CNT = STABLE_CNT_DEF
`ifdef BUTTON_DEBOUNCE_LONG_PRESS_EN
   , parameter int LONG_CNT = LONG_CNT_DEF
`endif
) (
   input  logic clk,
   input  logic reset,
   input  logic tick,
   input  logic btn,
   output logic level,
   output logic press,
   output logic rel,
   output logic toggle,
   output logic long_press
);

   localparam int SW = cnt_w(STABLE_CNT);
   localparam logic [SW-1:0] S_LAST = SW'(STABLE_CNT - 1);

   logic meta;
   logic sync;

   btn_state_t state;
   btn_state_t state_nx;
   logic [SW-1:0] cnt;
   logic [SW-1:0] cnt_nx;
   logic press_nx;
   logic rel_nx;
   logic toggle_nx;

   // The debounced level is fully encoded by the FSM state.
   assign level = (state == PRESSED) || (state == RELEASING);

   always_comb begin
      state_nx  = state;
      cnt_nx    = cnt;
      press_nx  = 1'b0;
      rel_nx    = 1'b0;
      toggle_nx = toggle;
      unique case (state)
         IDLE, ARMING: begin
            if (tick && sync) begin
               if (cnt == S_LAST) begin
                  state_nx  = PRESSED;
                  cnt_nx    = '0;
                  press_nx  = 1'b1;
                  toggle_nx = ~toggle;
               end else begin
                  state_nx = ARMING;
                  cnt_nx   = cnt + 1'b1;
               end
            end else if (tick) begin
               state_nx = IDLE;
               cnt_nx   = '0;
            end
         end
         PRESSED, RELEASING: begin
            if (tick && !sync) begin
               if (cnt == S_LAST) begin
                  state_nx = IDLE;
                  cnt_nx   = '0;
                  rel_nx   = 1'b1;
               end else begin
                  state_nx = RELEASING;
                  cnt_nx   = cnt + 1'b1;
               end
            end else if (tick) begin
               state_nx = PRESSED;
               cnt_nx   = '0;
            end
         end
         default: begin
            state_nx = IDLE;
            cnt_nx   = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         meta   <= 1'b0;
         sync   <= 1'b0;
         state  <= IDLE;
         cnt    <= '0;
         press  <= 1'b0;
         rel    <= 1'b0;
         toggle <= 1'b0;
      end else begin
         meta   <= btn;
         sync   <= meta;
         state  <= state_nx;
         cnt    <= cnt_nx;
         press  <= press_nx;
         rel    <= rel_nx;
         toggle <= toggle_nx;
      end
   end

`ifdef BUTTON_DEBOUNCE_LONG_PRESS_EN
   localparam int HW = cnt_w(LONG_CNT);
   localparam logic [HW-1:0] H_LIM = HW'(LONG_CNT);

   logic [HW-1:0] hold;
   logic [HW-1:0] hold_nx;
   logic long_nx;

   // Hold saturates at LONG_CNT, so the pulse cannot repeat.
   always_comb begin
      hold_nx = hold;
      long_nx = 1'b0;
      if (state != PRESSED || state_nx != PRESSED) begin
         hold_nx = '0;
      end else if (tick && hold != H_LIM) begin
         hold_nx = hold + 1'b1;
         long_nx = (hold == H_LIM - 1'b1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         hold       <= '0;
         long_press <= 1'b0;
      end else begin
         hold       <= hold_nx;
         long_press <= long_nx;
      end
   end
`else
   assign long_press = 1'b0;
`endif

endmodule

// File: rtl/button_debounce_bank.sv
// Bank of N_CH debounced buttons sharing one sample-tick prescaler.
// Define BUTTON_DEBOUNCE_LONG_PRESS_EN to enable long_o pulses.
module button_debounce_bank
   import button_pkg::*;
#(
   parameter int N_CH       = N_CH_DEF,
   parameter int TICK_DIV   = TICK_DIV_DEF,
   parameter int STABLE_CNT = STABLE_CNT_DEF,
   parameter int LONG_CNT   = LONG_CNT_DEF
) (
   input  logic clk,
   input  logic reset,
   button_debounce_bank_if.slave bus
);

   localparam int PW = (TICK_DIV <= 1) ? 1 : $clog2(TICK_DIV);
   localparam logic [PW-1:0] P_LAST = PW'(TICK_DIV - 1);

   if (N_CH < 1 || TICK_DIV < 1 || STABLE_CNT < 1 || LONG_CNT < 1) begin : g_bad_param
      $error("button_debounce_bank: all parameters must be >= 1");
   end

   logic [PW-1:0] pre;
   logic tick;

   logic [N_CH-1:0] level;
   logic [N_CH-1:0] press;
   logic [N_CH-1:0] rel;
   logic [N_CH-1:0] toggle;
   logic [N_CH-1:0] long_press;

   // Tick is high for the single cycle the prescaler holds TICK_DIV-1.
   assign tick = (pre == P_LAST);

   always_ff @(posedge clk) begin
      if (reset) begin
         pre <= '0;
      end else if (tick) begin
         pre <= '0;
      end else begin
         pre <= pre + 1'b1;
      end
   end

   for (genvar i = 0; i < N_CH; i++) begin : g_ch
      button_channel #(
         .STABLE_CNT(STABLE_CNT)
`ifdef BUTTON_DEBOUNCE_LONG_PRESS_EN
         , .LONG_CNT(LONG_CNT)
`endif
      ) u_ch (
         .clk       (clk),
         .reset     (reset),
         .tick      (tick),
         .btn       (bus.btn_in[i]),
         .level     (level[i]),
         .press     (press[i]),
         .rel       (rel[i]),
         .toggle    (toggle[i]),
         .long_press(long_press[i])
      );
   end

   assign bus.level_o   = level;
   assign bus.press_o   = press;
   assign bus.release_o = rel;
   assign bus.toggle_o  = toggle;
   assign bus.long_o    = long_press;

endmodule
